// File: rtl/mod_add_sub_pipe_if.sv
// Valid/ready operand and result channel of the pipelined modular adder/subtractor.
interface mod_add_sub_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             wrap;

   modport master (
      output in_valid, a, b, mode, out_ready,
      input  in_ready, out_valid, result, wrap
   );

   modport slave (
      input  in_valid, a, b, mode, out_ready,
      output in_ready, out_valid, result, wrap
   );
endinterface

// File: rtl/mod_add_sub_pipe.sv
// Two-stage modular add/subtract: S1 forms the raw WIDTH+1-bit sum/difference,
// S2 folds it back into [0, Q) and flags whether a correction was applied.
module mod_add_sub_pipe #(
   parameter int WIDTH = 16,
   parameter int Q     = 12289,
   parameter int CNT_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   mod_add_sub_pipe_if.slave   bus,
   output logic [CNT_W-1:0]    op_count
);
   localparam logic [WIDTH:0] QX = (WIDTH+1)'(Q);

   logic             s1_valid;
   logic             s1_mode;
   logic [WIDTH:0]   s1_raw;
   logic             s2_valid;
   logic [WIDTH-1:0] s2_result;
   logic             s2_wrap;

   logic             s1_adv;
   logic             s2_adv;
   logic [WIDTH:0]   raw_in;
   logic [WIDTH-1:0] corr;
   logic             corr_wrap;

   always_comb begin
      s2_adv = !s2_valid || bus.out_ready;
      s1_adv = !s1_valid || s2_adv;
   end

   // Subtraction keeps the borrow in the MSB so S2 can test the sign directly.
   always_comb begin
      if (bus.mode) raw_in = {1'b0, bus.a} - {1'b0, bus.b};
      else          raw_in = {1'b0, bus.a} + {1'b0, bus.b};
   end

   always_comb begin
      corr      = s1_raw[WIDTH-1:0];
      corr_wrap = 1'b0;
      if (s1_mode) begin
         if (s1_raw[WIDTH]) begin
            corr      = WIDTH'(s1_raw + QX);
            corr_wrap = 1'b1;
         end
      end else if (s1_raw >= QX) begin
         corr      = WIDTH'(s1_raw - QX);
         corr_wrap = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_mode  <= 1'b0;
         s1_raw   <= '0;
      end else if (s1_adv) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_mode <= bus.mode;
            s1_raw  <= raw_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_wrap   <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_result <= corr;
            s2_wrap   <= corr_wrap;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                              op_count <= '0;
      else if (s2_valid && bus.out_ready)   op_count <= op_count + CNT_W'(1);
   end

   assign bus.in_ready  = s1_adv;
   assign bus.out_valid = s2_valid;
   assign bus.result    = s2_result;
   assign bus.wrap      = s2_wrap;
endmodule

// File: tb/tb_mod_add_sub_pipe.sv
// Bench for mod_add_sub_pipe: directed literal cases plus random streaming against a queue model.
module tb_mod_add_sub_pipe;
   localparam int WIDTH = 16;
   localparam int Q     = 12289;
   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [CNT_W-1:0] op_count;

   mod_add_sub_pipe_if #(.WIDTH(WIDTH)) bus ();

   mod_add_sub_pipe #(.WIDTH(WIDTH), .Q(Q), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .op_count (op_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int r;
      int w;
      int c;
   } exp_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int unsigned mcount   = 0;
   exp_t        mq[$];
   int          got_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [63:0] got, logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic exp_t model(int a, int b, int m, int c);
      exp_t e;
      e.c = c;
      if (m == 0) begin
         if (a + b >= Q) begin e.r = a + b - Q; e.w = 1; end
         else            begin e.r = a + b;     e.w = 0; end
      end else begin
         if (a < b) begin e.r = a + Q - b; e.w = 1; end
         else       begin e.r = a - b;     e.w = 0; end
      end
      return e;
   endfunction

   // Occupancy model: oldest accepted op is on the output two cycles after its handshake.
   always @(negedge clk) begin
      bit ev;
      if (rst) begin
         mq.delete();
         mcount = 0;
      end else begin
         ev = (mq.size() > 0) && ((cyc - mq[0].c) >= 2);
         check("in_ready", bus.in_ready, (mq.size() < 2) || bus.out_ready);
         check("out_valid", bus.out_valid, ev);
         check("op_count", op_count, mcount);
         if (ev) begin
            check("result", bus.result, mq[0].r);
            check("wrap", bus.wrap, mq[0].w);
            if (bus.out_ready) begin
               got_q.push_back(int'(bus.result));
               void'(mq.pop_front());
               mcount++;
            end
         end
         if (bus.in_valid && bus.in_ready)
            mq.push_back(model(int'(bus.a), int'(bus.b), int'(bus.mode), cyc));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic do_op(string name, int a, int b, int m, int er, int ew);
      bit acc = 0;
      int t   = 0;
      bus.out_ready = 1'b1;
      bus.a = WIDTH'(a);
      bus.b = WIDTH'(b);
      bus.mode = m[0];
      bus.in_valid = 1'b1;
      while (!acc && t < 20) begin
         @(negedge clk);
         acc = bus.in_ready;
         step();
         t++;
      end
      bus.in_valid = 1'b0;
      if (!acc) check({name, "_accept"}, 0, 1);
      check({name, "_lat1"}, bus.out_valid, 0);
      step();
      check({name, "_valid"}, bus.out_valid, 1);
      check({name, "_res"}, bus.result, er);
      check({name, "_wrap"}, bus.wrap, ew);
      step();
   endtask

   initial begin
      int i;
      int t;
      int acc_n;
      int ready_lo;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a = '0; bus.b = '0; bus.mode = 1'b0;
      step();
      step();
      rst = 1'b0;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_result", bus.result, 0);
      check("rst_wrap", bus.wrap, 0);
      check("rst_op_count", op_count, 0);
      check("rst_in_ready", bus.in_ready, 1);

      do_op("add_basic", 5, 7, 0, 12, 0);
      do_op("add_wrap1", 12288, 1, 0, 0, 1);
      do_op("add_wrapmax", 12288, 12288, 0, 12287, 1);
      do_op("add_edge", 6144, 6144, 0, 12288, 0);
      do_op("sub_neg", 3, 5, 1, 12287, 1);
      do_op("sub_zero", 5, 5, 1, 0, 0);
      do_op("sub_max", 0, 12288, 1, 1, 1);
      check("directed_count", op_count, 7);

      // Backpressure: only two operations fit while the output is stalled.
      reset_dut();
      got_q.delete();
      i = 0;
      for (int k = 0; k < 6; k++) begin
         bus.in_valid = 1'b1;
         bus.a = WIDTH'(i + 1); bus.b = WIDTH'(i + 1); bus.mode = 1'b0;
         @(negedge clk);
         if (bus.in_ready) i++;
         step();
      end
      check("bp_accepted", i, 2);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_result", bus.result, 2);
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_ready", bus.in_ready, 1);
      t = 0;
      while (i < 4 && t < 20) begin
         bus.a = WIDTH'(i + 1); bus.b = WIDTH'(i + 1);
         @(negedge clk);
         if (bus.in_ready) i++;
         step();
         t++;
      end
      bus.in_valid = 1'b0;
      repeat (4) step();
      check("bp_out_n", got_q.size(), 4);
      for (int k = 0; k < 4; k++)
         if (k < got_q.size()) check("bp_order", got_q[k], 2 * (k + 1));
      check("bp_op_count", op_count, 4);

      // Reset with two ops in flight and a third offered alongside rst.
      reset_dut();
      bus.out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bus.in_valid = 1'b1;
         bus.a = WIDTH'(10 * (k + 1)); bus.b = WIDTH'(10 * (k + 1)); bus.mode = 1'b0;
         step();
      end
      bus.a = 30; bus.b = 30;
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.in_valid = 1'b0;
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_op_count", op_count, 0);
      check("mid_rst_in_ready", bus.in_ready, 1);
      got_q.delete();
      bus.out_ready = 1'b1;
      repeat (5) step();
      check("mid_rst_no_ghost", got_q.size(), 0);

      // Random streaming with random handshakes.
      reset_dut();
      acc_n = 0;
      t = 0;
      while (acc_n < 200 && t < 5000) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.a         = WIDTH'($urandom_range(0, Q - 1));
         bus.b         = WIDTH'($urandom_range(0, Q - 1));
         bus.mode      = 1'($urandom_range(0, 1));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) acc_n++;
         step();
         t++;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      repeat (5) step();
      check("stream_accepted", acc_n, 200);
      check("stream_op_count", op_count, 200);
      check("stream_drained", mq.size(), 0);

      // Full throughput: continuous handshakes leave no bubbles.
      reset_dut();
      ready_lo = 0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 30; k++) begin
         bus.in_valid = 1'b1;
         bus.a = WIDTH'($urandom_range(0, Q - 1));
         bus.b = WIDTH'($urandom_range(0, Q - 1));
         bus.mode = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (!bus.in_ready) ready_lo++;
         step();
      end
      bus.in_valid = 1'b0;
      check("tput_ready_gaps", ready_lo, 0);
      check("tput_op_count", op_count, 28);
      repeat (4) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
